// File: rtl/adder_share_scheduler_if.sv
// Bundles the request, shared-adder and response signals of adder_share_scheduler.
// Handshake: a response transfers on a rising edge where RSP_VALID and RSP_READY are both high.
interface adder_share_scheduler_if #(
    parameter int N = 4,
    parameter int W = 32
);
    localparam int IDW = $clog2(N);

    logic [N-1:0]   REQ;
    logic [N*W-1:0] REQ_A;
    logic [N*W-1:0] REQ_B;
    logic [N-1:0]   ACK;
    logic [W-1:0]   ADD_A;
    logic [W-1:0]   ADD_B;
    logic [W-1:0]   ADD_S;
    logic           ADD_COUT;
    logic           RSP_VALID;
    logic           RSP_READY;
    logic [IDW-1:0] RSP_ID;
    logic [W-1:0]   RSP_S;
    logic           RSP_COUT;

    modport master (
        output REQ, REQ_A, REQ_B, ADD_S, ADD_COUT, RSP_READY,
        input  ACK, ADD_A, ADD_B, RSP_VALID, RSP_ID, RSP_S, RSP_COUT
    );

    modport slave (
        input  REQ, REQ_A, REQ_B, ADD_S, ADD_COUT, RSP_READY,
        output ACK, ADD_A, ADD_B, RSP_VALID, RSP_ID, RSP_S, RSP_COUT
    );
endinterface

// File: rtl/adder_share_scheduler.sv
// Round-robin time-sharing of one external adder among N requesters, one operation in flight.
// Define ADDER_SAT_EN to saturate the captured sum to all-ones when the adder carries out.
module adder_share_scheduler #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int ADD_LAT = 2,
    localparam int IDW    = $clog2(N)
) (
    input  logic                    CLK,
    input  logic                    RST,
    adder_share_scheduler_if.slave  bus,
    output logic [1:0]              dbg_state
);
    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [W-1:0]   add_a_q, add_a_d;
    logic [W-1:0]   add_b_q, add_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0] rsp_id_q, rsp_id_d;
    logic [W-1:0]   rsp_s_q, rsp_s_d;
    logic           rsp_cout_q, rsp_cout_d;

    logic [W-1:0]   req_a_arr [N];
    logic [W-1:0]   req_b_arr [N];
    logic [IDW-1:0] grant;
    logic           grant_vld;
    int             cand;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a_arr[i] = bus.REQ_A[i*W +: W];
            req_b_arr[i] = bus.REQ_B[i*W +: W];
        end
    end

    // Scan offsets from far to near so the nearest set bit at or after ptr_q wins.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int i = N - 1; i >= 0; i--) begin
            cand = int'(ptr_q) + i;
            if (cand >= N) cand = cand - N;
            if (bus.REQ[cand[IDW-1:0]]) begin
                grant     = cand[IDW-1:0];
                grant_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        cnt_d       = cnt_q;
        ack_d       = '0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_s_d     = rsp_s_q;
        rsp_cout_d  = rsp_cout_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    add_a_d      = req_a_arr[grant];
                    add_b_d      = req_b_arr[grant];
                    id_d         = grant;
                    ack_d[grant] = 1'b1;
                    cnt_d        = CW'(ADD_LAT - 1);
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
`ifdef ADDER_SAT_EN
                    rsp_s_d = bus.ADD_COUT ? {W{1'b1}} : bus.ADD_S;
`else
                    rsp_s_d = bus.ADD_S;
`endif
                    rsp_cout_d  = bus.ADD_COUT;
                    rsp_id_d    = id_q;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Pointer moves only on completion so every holder of REQ is reached within N operations.
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = (id_q == IDW'(N - 1)) ? '0 : id_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            id_q        <= '0;
            cnt_q       <= '0;
            ack_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_s_q     <= '0;
            rsp_cout_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            cnt_q       <= cnt_d;
            ack_q       <= ack_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_s_q     <= rsp_s_d;
            rsp_cout_q  <= rsp_cout_d;
        end
    end

    assign bus.ACK       = ack_q;
    assign bus.ADD_A     = add_a_q;
    assign bus.ADD_B     = add_b_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_ID    = rsp_id_q;
    assign bus.RSP_S     = rsp_s_q;
    assign bus.RSP_COUT  = rsp_cout_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_adder_share_scheduler.sv
// Bench for adder_share_scheduler: default build plus an ADD_LAT=1 instance, combinational adder model.
module tb_adder_share_scheduler;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int RW = 2 + 1 + W;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic [1:0] dbg_state;
    logic [1:0] dbg_state1;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m    = 0;
    logic [W-1:0]  a_m [N];
    logic [W-1:0]  b_m [N];
    logic [RW-1:0] exp_q [$];

    adder_share_scheduler_if #(.N(N), .W(W)) bus ();
    adder_share_scheduler_if #(.N(N), .W(W)) bus1 ();

    adder_share_scheduler #(.N(N), .W(W), .ADD_LAT(2)) dut (
        .CLK(CLK), .RST(RST), .bus(bus.slave), .dbg_state(dbg_state)
    );
    adder_share_scheduler #(.N(N), .W(W), .ADD_LAT(1)) dut1 (
        .CLK(CLK), .RST(RST), .bus(bus1.slave), .dbg_state(dbg_state1)
    );

    assign {bus.ADD_COUT, bus.ADD_S}   = {1'b0, bus.ADD_A} + {1'b0, bus.ADD_B};
    assign {bus1.ADD_COUT, bus1.ADD_S} = {1'b0, bus1.ADD_A} + {1'b0, bus1.ADD_B};

    always #5 CLK = ~CLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    function automatic logic [RW-1:0] exp_rsp(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0]   full;
        logic [W-1:0] s;
        full = {1'b0, a} + {1'b0, b};
        s    = full[W-1:0];
`ifdef ADDER_SAT_EN
        if (full[W]) s = '1;
`endif
        return {2'(id), full[W], s};
    endfunction

    function automatic logic [RW-1:0] obs_rsp();
        return {bus.RSP_ID, bus.RSP_COUT, bus.RSP_S};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        a_m[i] = a;
        b_m[i] = b;
        bus.REQ_A[i*W +: W] = a;
        bus.REQ_B[i*W +: W] = b;
    endtask

    task automatic wait_ack(output logic [N-1:0] ack);
        ack = '0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (bus.ACK != '0) begin
                ack = bus.ACK;
                break;
            end
        end
    endtask

    task automatic collect_rsp(output bit got, output logic [RW-1:0] v, output int lat);
        got = 1'b0;
        v   = '0;
        lat = 0;
        for (int n = 0; n < 50; n++) begin
            tick();
            lat++;
            if (bus.RSP_VALID) begin
                got = 1'b1;
                v   = obs_rsp();
                break;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (3) tick();
        RST = 1'b0;
        n_checks++;
        if ({bus.ACK, bus.ADD_A, bus.ADD_B, bus.RSP_VALID, bus.RSP_ID, bus.RSP_S, bus.RSP_COUT} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ack=%b a=%h b=%h v=%b id=%0d s=%h c=%b required all zero",
                     bus.ACK, bus.ADD_A, bus.ADD_B, bus.RSP_VALID, bus.RSP_ID, bus.RSP_S, bus.RSP_COUT);
        end
        n_checks++;
        if (dbg_state !== 2'd0 || dbg_state1 !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: got=%0d/%0d required=0/0", dbg_state, dbg_state1);
        end
        n_checks++;
        if (bus1.RSP_VALID !== 1'b0 || bus1.ACK !== '0) begin
            n_fail++;
            $display("FAIL reset_lat1: valid=%b ack=%b required 0/0", bus1.RSP_VALID, bus1.ACK);
        end
        ptr_m = 0;
    endtask

    task automatic test_fairness(input logic [N-1:0] mask);
        logic [N-1:0]  req, ack;
        logic [RW-1:0] v, e;
        bit            got;
        int            g, lat;
        bus.RSP_READY = 1'b1;
        req = mask;
        for (int i = 0; i < N; i++) set_ops(i, W'($urandom), W'($urandom));
        bus.REQ = req;
        while (req != '0) begin
            g = rr_pick(req, ptr_m);
            exp_q.push_back(exp_rsp(g, a_m[g], b_m[g]));
            wait_ack(ack);
            n_checks++;
            if (ack !== (N'(1) << g)) begin
                n_fail++;
                $display("FAIL fair_grant: mask=%b ack=%b required=%b", mask, ack, N'(1) << g);
            end
            req[g] = 1'b0;
            bus.REQ = req;
            collect_rsp(got, v, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (!got || v !== e) begin
                n_fail++;
                $display("FAIL fair_rsp: got=%0b rsp=%h required=%h", got, v, e);
            end
            tick();
            ptr_m = (g + 1) % N;
        end
    endtask

    task automatic test_single();
        logic [N-1:0]  ack;
        logic [RW-1:0] e;
        bit            stable;
        int            lat;
        bus.RSP_READY = 1'b1;
        set_ops(0, 32'd5, 32'd7);
        exp_q.push_back(exp_rsp(0, 32'd5, 32'd7));
        bus.REQ = 4'b0001;
        wait_ack(ack);
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ack: got=%b required=0001", ack);
        end
        bus.REQ = '0;
        stable = (bus.ADD_A === 32'd5) && (bus.ADD_B === 32'd7);
        lat = 0;
        while (!bus.RSP_VALID && lat < 20) begin
            tick();
            lat++;
            if (bus.ACK !== '0 || bus.ADD_A !== 32'd5 || bus.ADD_B !== 32'd7) stable = 1'b0;
        end
        n_checks++;
        if (!stable) begin
            n_fail++;
            $display("FAIL single_operands: a=%0d b=%0d ack=%b required 5/7 and ack pulse one cycle",
                     bus.ADD_A, bus.ADD_B, bus.ACK);
        end
        n_checks++;
        if (lat != 2) begin
            n_fail++;
            $display("FAIL single_latency: got=%0d edges required=2", lat);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (bus.RSP_VALID !== 1'b1 || obs_rsp() !== e) begin
            n_fail++;
            $display("FAIL single_rsp: v=%b rsp=%h required=%h", bus.RSP_VALID, obs_rsp(), e);
        end
        tick();
        n_checks++;
        if (bus.RSP_VALID !== 1'b0) begin
            n_fail++;
            $display("FAIL single_consume: valid=%b required=0", bus.RSP_VALID);
        end
        ptr_m = 1;
    endtask

    task automatic test_backpressure();
        logic [N-1:0]  ack;
        logic [RW-1:0] v, e;
        bit            got, held;
        int            lat;
        bus.RSP_READY = 1'b0;
        set_ops(0, W'($urandom), W'($urandom));
        set_ops(2, W'($urandom), W'($urandom));
        exp_q.push_back(exp_rsp(0, a_m[0], b_m[0]));
        bus.REQ = 4'b0001;
        wait_ack(ack);
        n_checks++;
        if (ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL bp_first_ack: got=%b required=0001", ack);
        end
        bus.REQ = 4'b0100;
        collect_rsp(got, v, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || v !== e) begin
            n_fail++;
            $display("FAIL bp_rsp: got=%0b rsp=%h required=%h", got, v, e);
        end
        held = 1'b1;
        repeat (5) begin
            tick();
            if (bus.RSP_VALID !== 1'b1 || obs_rsp() !== e || bus.ACK !== '0) held = 1'b0;
        end
        n_checks++;
        if (!held) begin
            n_fail++;
            $display("FAIL bp_hold: v=%b rsp=%h ack=%b required v=1 rsp=%h ack=0000",
                     bus.RSP_VALID, obs_rsp(), bus.ACK, e);
        end
        bus.RSP_READY = 1'b1;
        tick();
        ptr_m = 1;
        n_checks++;
        if (bus.RSP_VALID !== 1'b0 || bus.ACK !== '0) begin
            n_fail++;
            $display("FAIL bp_release: v=%b ack=%b required 0/0000", bus.RSP_VALID, bus.ACK);
        end
        exp_q.push_back(exp_rsp(rr_pick(4'b0100, ptr_m), a_m[2], b_m[2]));
        tick();
        n_checks++;
        if (bus.ACK !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_second_ack: got=%b required=0100", bus.ACK);
        end
        bus.REQ = '0;
        collect_rsp(got, v, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || v !== e) begin
            n_fail++;
            $display("FAIL bp_second_rsp: got=%0b rsp=%h required=%h", got, v, e);
        end
        tick();
        ptr_m = 3;
    endtask

    task automatic test_carry();
        logic [N-1:0]  ack;
        logic [RW-1:0] v;
        logic [W-1:0]  s_req;
        bit            got;
        int            lat;
`ifdef ADDER_SAT_EN
        s_req = 32'hFFFF_FFFF;
`else
        s_req = 32'h0000_0001;
`endif
        bus.RSP_READY = 1'b1;
        set_ops(3, 32'hFFFF_FFFF, 32'h0000_0002);
        bus.REQ = 4'b1000;
        wait_ack(ack);
        n_checks++;
        if (ack !== 4'b1000) begin
            n_fail++;
            $display("FAIL carry_ack: got=%b required=1000", ack);
        end
        bus.REQ = '0;
        collect_rsp(got, v, lat);
        n_checks++;
        if (!got || bus.RSP_S !== s_req) begin
            n_fail++;
            $display("FAIL carry_sum: got=%0b s=%h required=%h", got, bus.RSP_S, s_req);
        end
        n_checks++;
        if (bus.RSP_COUT !== 1'b1 || bus.RSP_ID !== 2'd3) begin
            n_fail++;
            $display("FAIL carry_cout: c=%b id=%0d required 1/3", bus.RSP_COUT, bus.RSP_ID);
        end
        tick();
        ptr_m = 0;
    endtask

    task automatic test_reset_wait();
        logic [N-1:0]  ack;
        logic [RW-1:0] v, e;
        bit            got, quiet;
        int            lat;
        bus.RSP_READY = 1'b1;
        set_ops(1, 32'd10, 32'd20);
        set_ops(2, 32'd30, 32'd40);
        bus.REQ = 4'b0010;
        wait_ack(ack);
        bus.REQ = '0;
        collect_rsp(got, v, lat);
        tick();
        n_checks++;
        if (ack !== 4'b0010 || !got) begin
            n_fail++;
            $display("FAIL rw_setup: ack=%b got=%0b required 0010/1", ack, got);
        end
        bus.REQ = 4'b0100;
        wait_ack(ack);
        n_checks++;
        if (ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL rw_ack: got=%b required=0100", ack);
        end
        bus.REQ = '0;
        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        n_checks++;
        if ({bus.ACK, bus.ADD_A, bus.ADD_B, bus.RSP_VALID, bus.RSP_ID, bus.RSP_S, bus.RSP_COUT} !== '0
            || dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL rw_outputs: ack=%b a=%h b=%h v=%b id=%0d s=%h st=%0d required all zero",
                     bus.ACK, bus.ADD_A, bus.ADD_B, bus.RSP_VALID, bus.RSP_ID, bus.RSP_S, dbg_state);
        end
        quiet = 1'b1;
        repeat (6) begin
            tick();
            if (bus.RSP_VALID !== 1'b0 || bus.ACK !== '0) quiet = 1'b0;
        end
        n_checks++;
        if (!quiet) begin
            n_fail++;
            $display("FAIL rw_quiet: v=%b ack=%b required 0/0000", bus.RSP_VALID, bus.ACK);
        end
        ptr_m = 0;
        // Requester 3 also asks: a pointer left at 2 would pick it instead of 1.
        set_ops(3, 32'd1, 32'd1);
        exp_q.push_back(exp_rsp(rr_pick(4'b1010, ptr_m), a_m[1], b_m[1]));
        bus.REQ = 4'b1010;
        wait_ack(ack);
        bus.REQ = '0;
        n_checks++;
        if (ack !== 4'b0010) begin
            n_fail++;
            $display("FAIL rw_ptr: got=%b required=0010", ack);
        end
        collect_rsp(got, v, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (!got || v !== e) begin
            n_fail++;
            $display("FAIL rw_rsp: got=%0b rsp=%h required=%h", got, v, e);
        end
        tick();
        ptr_m = 2;
    endtask

    task automatic test_lat1();
        logic [N-1:0] ack;
        int           lat;
        bus1.RSP_READY = 1'b1;
        bus1.REQ_A[2*W +: W] = 32'd3;
        bus1.REQ_B[2*W +: W] = 32'd4;
        bus1.REQ = 4'b0100;
        ack = '0;
        for (int n = 0; n < 50; n++) begin
            tick();
            if (bus1.ACK != '0) begin
                ack = bus1.ACK;
                break;
            end
        end
        n_checks++;
        if (ack !== 4'b0100) begin
            n_fail++;
            $display("FAIL lat1_ack: got=%b required=0100", ack);
        end
        bus1.REQ = '0;
        lat = 0;
        while (!bus1.RSP_VALID && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL lat1_latency: got=%0d edges required=1", lat);
        end
        n_checks++;
        if (bus1.RSP_VALID !== 1'b1 || bus1.RSP_S !== 32'd7 || bus1.RSP_ID !== 2'd2 || bus1.RSP_COUT !== 1'b0) begin
            n_fail++;
            $display("FAIL lat1_rsp: v=%b s=%0d id=%0d c=%b required 1/7/2/0",
                     bus1.RSP_VALID, bus1.RSP_S, bus1.RSP_ID, bus1.RSP_COUT);
        end
        tick();
    endtask

    initial begin
        bus.REQ = '0;  bus.REQ_A = '0;  bus.REQ_B = '0;  bus.RSP_READY = 1'b0;
        bus1.REQ = '0; bus1.REQ_A = '0; bus1.REQ_B = '0; bus1.RSP_READY = 1'b0;
        test_reset();
        test_fairness(4'b1111);
        test_fairness(4'b1001);
        test_single();
        test_backpressure();
        test_carry();
        for (int r = 0; r < 4; r++) test_fairness(N'($urandom_range(1, 15)));
        test_reset_wait();
        test_lat1();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: got=%0d pending required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
